// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer.
//   mode_t    : pattern mode encoding, also the value seen on cur_mode.
//   DIR_LEFT / DIR_RIGHT : bounce direction encoding.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous level into the clk domain and turns each rising edge
// into a single-cycle registered pulse.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   async_in  in   level from another clock domain (or a pin)
//   tick      out  one-cycle pulse per synchronised rising edge of async_in
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 form the metastability synchroniser; s3 holds the previous
    // synchronised level so the edge compare only sees settled values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives a bank of LEDs with an off / blink / chase / bounce pattern, stepped
// by rising edges of a slow divided-clock bit that is asynchronous to clk.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   div_in     in   divided clock bit, asynchronous to clk
//   mode_load  in   one-cycle request to change pattern mode
//   mode       in   requested mode (mode_t encoding), sampled with mode_load
//   led        out  LED drive, registered
//   tick       out  one-cycle pulse per synchronised div_in rising edge
//   busy       out  a mode request is pending and not yet applied
//   cur_mode   out  mode currently running
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             mode_load,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       cur_mode
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_ONE  = CNT_W'(1);

    // Pattern loaded when a mode is (re)applied.
    function automatic logic [LED_W-1:0] load_pattern(input mode_t m);
        logic [LED_W-1:0] l;
        case (m)
            MODE_BLINK:  l = '1;
            MODE_CHASE:  l = LED_W'(1);
            MODE_BOUNCE: l = LED_W'(1);
            default:     l = '0;
        endcase
        return l;
    endfunction

    // One pattern step; returns {next_dir, next_led}. The bounce direction
    // flips on the step that lands on an end bit so no end is shown twice.
    function automatic logic [LED_W:0] step_pattern(input mode_t m,
                                                    input logic [LED_W-1:0] l,
                                                    input logic d);
        logic [LED_W-1:0] nl;
        logic             nd;
        nl = l;
        nd = d;
        case (m)
            MODE_BLINK: nl = ~l;
            MODE_CHASE: nl = {l[LED_W-2:0], l[LED_W-1]};
            MODE_BOUNCE: begin
                if (d == DIR_LEFT) begin
                    nl = l << 1;
                    nd = nl[LED_W-1] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    nl = l >> 1;
                    nd = nl[0] ? DIR_LEFT : DIR_RIGHT;
                end
            end
            default: nl = '0;
        endcase
        return {nd, nl};
    endfunction

    logic             tick_int;
    mode_t            cur_q,  cur_d;
    mode_t            pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [LED_W-1:0] led_q,  led_d;
    logic             dir_q,  dir_d;
    logic [CNT_W-1:0] pre_q,  pre_d;
    logic             apply;
    mode_t            apply_mode;

    // Input stage: div_in synchronised and edge-detected into tick_int.
    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (div_in),
        .tick     (tick_int)
    );

    // Next-state: mode request handling, apply, prescaled pattern step.
    always_comb begin
        cur_d      = cur_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        led_d      = led_q;
        dir_d      = dir_q;
        pre_d      = pre_q;
        apply      = 1'b0;
        apply_mode = cur_q;

        if (tick_int) begin
            // A load coinciding with the tick bypasses the pending register.
            if (mode_load) begin
                apply      = 1'b1;
                apply_mode = mode_t'(mode);
            end else if (busy_q) begin
                apply      = 1'b1;
                apply_mode = pend_q;
            end
            busy_d = 1'b0;
        end else if (mode_load) begin
            pend_d = mode_t'(mode);
            busy_d = 1'b1;
        end

        if (apply) begin
            cur_d = apply_mode;
            pre_d = '0;
            dir_d = DIR_LEFT;
            led_d = load_pattern(apply_mode);
        end else if (tick_int) begin
            if (pre_q == PRE_LAST) begin
                pre_d          = '0;
                {dir_d, led_d} = step_pattern(cur_q, led_q, dir_q);
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    // State register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= MODE_OFF;
            pend_q <= MODE_OFF;
            busy_q <= 1'b0;
            led_q  <= '0;
            dir_q  <= DIR_LEFT;
            pre_q  <= '0;
        end else begin
            cur_q  <= cur_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            pre_q  <= pre_d;
        end
    end

    assign led      = led_q;
    assign tick     = tick_int;
    assign busy     = busy_q;
    assign cur_mode = cur_q;

endmodule
